// File: rtl/gpio_apb_arbiter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// gpio_apb_arbiter
//
// Two-requester APB master in front of the single gpio_apb slave port.
// Each requester presents a command on a valid/ready port. The arbiter picks
// one command, runs the APB SETUP/ACCESS sequence with PREADY wait states,
// and returns read data and error status to the requester that won.
// A wait-state watchdog aborts a transfer that has stalled for TIMEOUT
// consecutive ACCESS cycles. Setting TIMEOUT to 0 disables the watchdog.
//
// Build option:
//   GPIO_ARB_FIXED_PRIO_EN - if defined, requester 0 always wins a tie.
//                            Otherwise the arbiter uses round-robin.
//
// Parameters:
//   ADDR_W   APB address width
//   DATA_W   APB data width
//   TIMEOUT  ACCESS cycles with PREADY=0 before abort (0 = no watchdog)
//
// Ports (every output is registered):
//   PCLK, PRESETn                     clock, async active-low reset
//   rX_valid/write/addr/wdata         requester X command (held until ready)
//   rX_ready                          one-cycle pulse: command accepted
//   rX_rsp_valid/rdata/err            one-cycle response pulse, data, error
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB master request
//   PRDATA/PREADY/PSLVERR             APB slave response
//   timeout_evt                       one-cycle pulse on watchdog abort
// ----------------------------------------------------------------------------
module gpio_apb_arbiter #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,

    input  logic              r0_valid,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ready,
    output logic              r0_rsp_valid,
    output logic [DATA_W-1:0] r0_rsp_rdata,
    output logic              r0_rsp_err,

    input  logic              r1_valid,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ready,
    output logic              r1_rsp_valid,
    output logic [DATA_W-1:0] r1_rsp_rdata,
    output logic              r1_rsp_err,

    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,

    output logic              timeout_evt
);

    // The counter must hold values up to TIMEOUT. It stays 1 bit wide
    // when the watchdog is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // The counter value seen on the last stalled ACCESS cycle before abort.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;     // requester that owns the current transfer
`ifndef GPIO_ARB_FIXED_PRIO_EN
    logic              last_q, last_d;       // requester granted most recently
`endif
    logic [CNT_W-1:0]  wait_q, wait_d;

    logic              any_req;
    logic              win;                  // 0 = requester 0, 1 = requester 1

    logic              rsp_fire;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    logic              psel_d, penable_d, pwrite_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;
    logic              ready0_d, ready1_d;
    logic              rsp_valid0_d, rsp_valid1_d;
    logic [DATA_W-1:0] rsp_rdata0_d, rsp_rdata1_d;
    logic              rsp_err0_d, rsp_err1_d;
    logic              tmo_d;

    // ------------------------------------------------------------------
    // Winner selection. This only matters when any_req is high.
    // ------------------------------------------------------------------
    always_comb begin
        any_req = r0_valid | r1_valid;
`ifdef GPIO_ARB_FIXED_PRIO_EN
        win = ~r0_valid;
`else
        if (r0_valid && r1_valid) begin
            win = ~last_q;
        end else begin
            win = ~r0_valid;
        end
`endif
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state, and the next value of every registered output
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
`ifndef GPIO_ARB_FIXED_PRIO_EN
        last_d       = last_q;
`endif
        wait_d       = wait_q;
        pwrite_d     = PWRITE;
        paddr_d      = PADDR;
        pwdata_d     = PWDATA;
        ready0_d     = 1'b0;
        ready1_d     = 1'b0;
        rsp_valid0_d = 1'b0;
        rsp_valid1_d = 1'b0;
        rsp_rdata0_d = r0_rsp_rdata;
        rsp_rdata1_d = r1_rsp_rdata;
        rsp_err0_d   = r0_rsp_err;
        rsp_err1_d   = r1_rsp_err;
        tmo_d        = 1'b0;
        rsp_fire     = 1'b0;
        rsp_data     = '0;
        rsp_err      = 1'b0;

        unique case (state_q)
            // RESP also arbitrates. This lets a new transfer start in the
            // cycle right after the previous response, with no idle cycle.
            IDLE, RESP: begin
                if (any_req) begin
                    state_d  = SETUP;
                    grant_d  = win;
`ifndef GPIO_ARB_FIXED_PRIO_EN
                    last_d   = win;
`endif
                    wait_d   = '0;
                    pwrite_d = win ? r1_write : r0_write;
                    paddr_d  = win ? r1_addr  : r0_addr;
                    pwdata_d = win ? r1_wdata : r0_wdata;
                    ready0_d = ~win;
                    ready1_d = win;
                end else begin
                    state_d = IDLE;
                end
            end

            SETUP: begin
                state_d = ACCESS;
            end

            ACCESS: begin
                if (PREADY) begin
                    rsp_fire = 1'b1;
                    rsp_data = PWRITE ? '0 : PRDATA;
                    rsp_err  = PSLVERR;
                    state_d  = RESP;
                end else if ((TIMEOUT != 0) && (wait_q == CNT_LAST)) begin
                    // This is the TIMEOUT-th stalled ACCESS cycle, so abort.
                    rsp_fire = 1'b1;
                    rsp_data = '0;
                    rsp_err  = 1'b1;
                    tmo_d    = 1'b1;
                    state_d  = RESP;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (rsp_fire) begin
            if (grant_q) begin
                rsp_valid1_d = 1'b1;
                rsp_rdata1_d = rsp_data;
                rsp_err1_d   = rsp_err;
            end else begin
                rsp_valid0_d = 1'b1;
                rsp_rdata0_d = rsp_data;
                rsp_err0_d   = rsp_err;
            end
        end

        // The APB strobes come from the state being entered. They are
        // registered, so they line up with that state.
        psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        penable_d = (state_d == ACCESS);
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            grant_q      <= 1'b0;
`ifndef GPIO_ARB_FIXED_PRIO_EN
            last_q       <= 1'b1;
`endif
            wait_q       <= '0;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            PWRITE       <= 1'b0;
            PADDR        <= '0;
            PWDATA       <= '0;
            r0_ready     <= 1'b0;
            r1_ready     <= 1'b0;
            r0_rsp_valid <= 1'b0;
            r1_rsp_valid <= 1'b0;
            r0_rsp_rdata <= '0;
            r1_rsp_rdata <= '0;
            r0_rsp_err   <= 1'b0;
            r1_rsp_err   <= 1'b0;
            timeout_evt  <= 1'b0;
        end else begin
            grant_q      <= grant_d;
`ifndef GPIO_ARB_FIXED_PRIO_EN
            last_q       <= last_d;
`endif
            wait_q       <= wait_d;
            PSEL         <= psel_d;
            PENABLE      <= penable_d;
            PWRITE       <= pwrite_d;
            PADDR        <= paddr_d;
            PWDATA       <= pwdata_d;
            r0_ready     <= ready0_d;
            r1_ready     <= ready1_d;
            r0_rsp_valid <= rsp_valid0_d;
            r1_rsp_valid <= rsp_valid1_d;
            r0_rsp_rdata <= rsp_rdata0_d;
            r1_rsp_rdata <= rsp_rdata1_d;
            r0_rsp_err   <= rsp_err0_d;
            r1_rsp_err   <= rsp_err1_d;
            timeout_evt  <= tmo_d;
        end
    end

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_gpio_apb_arbiter
//
// Self-checking bench for gpio_apb_arbiter. It runs directed scenarios
// followed by randomized traffic from both requesters. The bench contains
// an APB slave (a register array plus per-address wait and error tables)
// and a reference model. The model computes each expected response when a
// command is issued and pushes it into a queue for that requester. A
// separate monitor pops each queue when the matching rsp_valid pulses.
// ----------------------------------------------------------------------------
module tb_gpio_apb_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int TMO    = 8;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b1;

    logic              r0_valid, r0_write, r0_ready, r0_rsp_valid, r0_rsp_err;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata, r0_rsp_rdata;
    logic              r1_valid, r1_write, r1_ready, r1_rsp_valid, r1_rsp_err;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata, r1_rsp_rdata;

    logic              PSEL, PENABLE, PWRITE, PREADY, PSLVERR, timeout_evt;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA, PRDATA;

    always #5 PCLK = ~PCLK;

    gpio_apb_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TMO)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .r0_valid    (r0_valid),
        .r0_write    (r0_write),
        .r0_addr     (r0_addr),
        .r0_wdata    (r0_wdata),
        .r0_ready    (r0_ready),
        .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_rdata(r0_rsp_rdata),
        .r0_rsp_err  (r0_rsp_err),
        .r1_valid    (r1_valid),
        .r1_write    (r1_write),
        .r1_addr     (r1_addr),
        .r1_wdata    (r1_wdata),
        .r1_ready    (r1_ready),
        .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_rdata(r1_rsp_rdata),
        .r1_rsp_err  (r1_rsp_err),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .timeout_evt (timeout_evt)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          lat;    // cycles from the ready pulse to rsp_valid
        logic        tmo;
    } exp_t;

    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    int          grants[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    // Slave environment and reference state
    int          waits_tab[64];
    bit          err_tab[64];
    logic [31:0] slave_mem[64];
    logic [31:0] ref_mem[64];
    bit          stuck = 1'b0;

    // Command each requester is currently presenting
    logic        cur_wr[2];
    logic [5:0]  cur_addr[2];
    logic [31:0] cur_wd[2];

    // Monitor state
    int          rdy_cyc[2];
    int          passed[2];
    int          mon_r;
    logic [5:0]  setup_addr;
    logic        setup_wr;
    logic [31:0] setup_wd;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic vld(input int r);
        return (r != 0) ? r1_valid : r0_valid;
    endfunction

    function automatic logic rdy(input int r);
        return (r != 0) ? r1_ready : r0_ready;
    endfunction

    task automatic drive(input int r, input logic v, input logic wr,
                         input logic [5:0] a, input logic [31:0] d);
        if (r == 0) begin
            r0_valid = v; r0_write = wr; r0_addr = a; r0_wdata = d;
        end else begin
            r1_valid = v; r1_write = wr; r1_addr = a; r1_wdata = d;
        end
    endtask

    // Reference model: expected response as seen by the requester
    task automatic model(input logic wr, input logic [5:0] a, input logic [31:0] d,
                         output exp_t e);
        if (stuck) begin
            e.rdata = '0; e.err = 1'b1; e.lat = TMO + 1; e.tmo = 1'b1;
        end else begin
            e.err   = err_tab[a];
            e.rdata = wr ? 32'h0 : ref_mem[a];
            e.lat   = waits_tab[a] + 2;
            e.tmo   = 1'b0;
            if (wr && !e.err) ref_mem[a] = d;
        end
    endtask

    // Present one command and hold it until the handshake. This task is
    // entered and left just after a rising edge.
    task automatic issue(input int r, input logic wr, input logic [5:0] a,
                         input logic [31:0] d, input bit imm);
        exp_t e;
        int   n;
        model(wr, a, d, e);
        if (r == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        cur_wr[r] = wr; cur_addr[r] = a; cur_wd[r] = d;
        drive(r, 1'b1, wr, a, d);
        n = 0;
        while (1) begin
            @(negedge PCLK);
            if (rdy(r)) break;
            n++;
            if (n > 300) begin
                checks++; errors++;
                $display("FAIL ready_timeout r%0d: no ready after %0d cycles, required within 300", r, n);
                break;
            end
        end
        if (imm) chk("ready_latency", n, 1);
        @(posedge PCLK); #1;
        drive(r, 1'b0, 1'b0, 6'h0, 32'h0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 400) begin
            @(negedge PCLK);
            n++;
        end
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d/%0d responses outstanding, required 0/0",
                     exp_q0.size(), exp_q1.size());
            exp_q0.delete(); exp_q1.delete();
        end
        @(posedge PCLK); #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_psel"},    PSEL, 0);
        chk({tag, "_penable"}, PENABLE, 0);
        chk({tag, "_pwrite"},  PWRITE, 0);
        chk({tag, "_paddr"},   PADDR, 0);
        chk({tag, "_pwdata"},  PWDATA, 0);
        chk({tag, "_ready"},   {r0_ready, r1_ready}, 0);
        chk({tag, "_rspv"},    {r0_rsp_valid, r1_rsp_valid}, 0);
        chk({tag, "_rdata0"},  r0_rsp_rdata, 0);
        chk({tag, "_rdata1"},  r1_rsp_rdata, 0);
        chk({tag, "_err"},     {r0_rsp_err, r1_rsp_err}, 0);
        chk({tag, "_tmo"},     timeout_evt, 0);
    endtask

    task automatic check_rsp(input int r, input logic [31:0] rd, input logic err);
        exp_t e;
        if ((r == 0 && exp_q0.size() == 0) || (r == 1 && exp_q1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp r%0d: rsp_valid=1 with nothing outstanding, required 0", r);
        end else begin
            e = (r == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk("rsp_rdata",    rd, e.rdata);
            chk("rsp_err",      err, e.err);
            chk("rsp_latency",  cyc - rdy_cyc[r], e.lat);
            chk("timeout_evt",  timeout_evt, e.tmo);
            chk("psel_in_resp", {PSEL, PENABLE}, 0);
        end
    endtask

    // APB slave. It responds after waits_tab[addr] stalled cycles, or
    // never while stuck is set.
    initial begin : slave
        int acc_cnt;
        acc_cnt = 0;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        forever begin
            @(posedge PCLK); #1;
            if (PSEL && PENABLE) begin
                acc_cnt++;
                if (!stuck && acc_cnt > waits_tab[PADDR]) begin
                    PREADY  = 1'b1;
                    PSLVERR = err_tab[PADDR];
                    PRDATA  = PWRITE ? $urandom : slave_mem[PADDR];
                    if (PWRITE && !err_tab[PADDR]) slave_mem[PADDR] = PWDATA;
                end else begin
                    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
                end
            end else begin
                acc_cnt = 0;
                PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
            end
        end
    end

    // Monitor: handshake, APB phase, stability, fairness and responses
    initial begin : monitor
        passed[0] = 0; passed[1] = 0;
        forever begin
            @(negedge PCLK);
            if (PRESETn) begin
                if (r0_ready || r1_ready) begin
                    mon_r = r1_ready ? 1 : 0;
                    chk("single_ready", r0_ready & r1_ready, 0);
                    grants.push_back(mon_r);
                    rdy_cyc[mon_r] = cyc;
                    chk("ready_while_valid", vld(mon_r), 1);
                    chk("setup_phase", {PSEL, PENABLE}, 2'b10);
                    chk("setup_paddr", PADDR, cur_addr[mon_r]);
                    chk("setup_pwrite", PWRITE, cur_wr[mon_r]);
                    if (cur_wr[mon_r]) chk("setup_pwdata", PWDATA, cur_wd[mon_r]);
                    setup_addr = PADDR; setup_wr = PWRITE; setup_wd = PWDATA;
                end
                if (PSEL && PENABLE) begin
                    chk("paddr_stable",  PADDR, setup_addr);
                    chk("pwrite_stable", PWRITE, setup_wr);
                    chk("pwdata_stable", PWDATA, setup_wd);
                end
`ifndef GPIO_ARB_FIXED_PRIO_EN
                // A waiting requester may be passed over at most once.
                for (int y = 0; y < 2; y++) begin
                    if (!vld(y) || rdy(y)) begin
                        passed[y] = 0;
                    end else if (rdy(1 - y)) begin
                        passed[y]++;
                        chk("rr_fairness_passed", passed[y] > 1, 0);
                    end
                end
`endif
                if (r0_rsp_valid) check_rsp(0, r0_rsp_rdata, r0_rsp_err);
                if (r1_rsp_valid) check_rsp(1, r1_rsp_rdata, r1_rsp_err);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "global timeout");
    end

    initial begin : stimulus
        int exp_g[4];
        int n;
        drive(0, 1'b0, 1'b0, 6'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 6'h0, 32'h0);
        for (int i = 0; i < 64; i++) begin
            waits_tab[i] = 0; err_tab[i] = 1'b0;
            slave_mem[i] = $urandom; ref_mem[i] = slave_mem[i];
        end

        // Reset state
        #2 PRESETn = 1'b0;
        #1 chk_zero_outputs("reset");
        repeat (3) @(posedge PCLK);
        @(negedge PCLK) PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Both requesters contend continuously from reset
        grants.delete();
        fork
            begin for (int i = 0; i < 4; i++) issue(0, 1'b0, 6'h10, 32'h0, 1'b0); end
            begin for (int i = 0; i < 4; i++) issue(1, 1'b0, 6'h14, 32'h0, 1'b0); end
        join
        drain();
`ifdef GPIO_ARB_FIXED_PRIO_EN
        exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 0;
`else
        exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`endif
        chk("grant_count", grants.size(), 8);
        for (int i = 0; i < 4 && i < grants.size(); i++) chk("grant_order", grants[i], exp_g[i]);

        // r0 writes, then r1 reads back
        issue(0, 1'b1, 6'h04, 32'hDEADBEEF, 1'b1);
        drain();
        issue(1, 1'b0, 6'h04, 32'h0, 1'b1);
        drain();

        // Three wait states on an r1 write
        waits_tab[6'h14] = 3;
        issue(1, 1'b1, 6'h14, 32'h1, 1'b1);
        drain();
        waits_tab[6'h14] = 0;

        // Slave error on an r0 read
        err_tab[6'h04] = 1'b1;
        issue(0, 1'b0, 6'h04, 32'h0, 1'b1);
        drain();
        err_tab[6'h04] = 1'b0;

        // Watchdog abort, then a normal transfer
        stuck = 1'b1;
        issue(0, 1'b0, 6'h08, 32'h0, 1'b1);
        drain();
        stuck = 1'b0;
        issue(0, 1'b0, 6'h08, 32'h0, 1'b1);
        drain();

        // Reset during ACCESS
        waits_tab[6'h0C] = 3;
        cur_wr[0] = 1'b0; cur_addr[0] = 6'h0C; cur_wd[0] = 32'h0;
        drive(0, 1'b1, 1'b0, 6'h0C, 32'h0);
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!(PSEL && PENABLE) && n < 20);
        chk("reached_access", PSEL && PENABLE, 1);
        PRESETn = 1'b0;
        #1;
        chk("async_rst_psel", PSEL, 0);
        chk("async_rst_penable", PENABLE, 0);
        drive(0, 1'b0, 1'b0, 6'h0, 32'h0);
        repeat (2) @(negedge PCLK);
        chk_zero_outputs("midrst");
        PRESETn = 1'b1;
        waits_tab[6'h0C] = 0;
        repeat (3) @(posedge PCLK);
        #1;
        issue(1, 1'b0, 6'h00, 32'h0, 1'b1);
        drain();

        // Random traffic. Each requester uses its own half of the address map.
        for (int i = 0; i < 64; i++) begin
            waits_tab[i] = $urandom_range(0, 3);
            err_tab[i]   = ($urandom_range(0, 7) == 0);
        end
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge PCLK); #1; end
                    issue(0, 1'($urandom_range(0, 1)), {1'b0, 5'($urandom)}, $urandom, 1'b0);
                end
            end
            begin
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge PCLK); #1; end
                    issue(1, 1'($urandom_range(0, 1)), {1'b1, 5'($urandom)}, $urandom, 1'b0);
                end
            end
        join
        drain();
        repeat (4) @(posedge PCLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
